// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port byte-memory arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // Bytes moved per word transfer (one memory beat per byte).
    localparam int WORD_BYTES = 4;

    // Consecutive contended data grants allowed before fetch gets a turn.
    localparam int STREAK_MAX = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared byte-memory port.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ack;
    logic [31:0]       dm_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one byte-wide memory,
// moving one big-endian 32-bit word per grant as four byte beats.
//
//   state | meaning
//   IDLE  | waiting; arbitrates and latches the winning request
//   XFER  | one byte beat per cycle, beat 0 carries bits 31:24
//   ACK   | transfer done; owner's ack/rdata registered on leaving
//
// The ack is registered, so it is seen in the cycle after ACK (back in
// IDLE). A requester that drops its request on seeing the ack is not
// re-sampled, and a requester that keeps it high is served again at once.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    import mips_mem_pkg::*;

    localparam int BEAT_W = $clog2(WORD_BYTES);

    localparam logic [1:0]        S_IDLE     = IDLE;
    localparam logic [1:0]        S_XFER     = XFER;
    localparam logic [1:0]        S_ACK      = ACK;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORD_BYTES - 1);
    localparam logic [1:0]        STREAK_SAT = 2'(STREAK_MAX);

    logic [1:0]        state_q,    state_d;
    logic [BEAT_W-1:0] beat_q,     beat_d;
    owner_e            owner_q,    owner_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic [1:0]        streak_q,   streak_d;
    logic              if_ack_q,   if_ack_d;
    logic              dm_ack_q,   dm_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic [BEAT_W-1:0] byte_sel;
    logic [31:0]       wdata_shift;

    // Next-state: arbitration in IDLE, beat sequencing in XFER, completion in ACK.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        streak_d   = streak_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.dm_req && !(bus.if_req && streak_q == STREAK_SAT)) begin
                    owner_d = OWN_DM;
                    addr_d  = bus.dm_addr;
                    we_d    = bus.dm_we;
                    wdata_d = bus.dm_wdata;
                    // Only a grant that actually made fetch wait counts.
                    if (bus.if_req) begin
                        streak_d = (streak_q == STREAK_SAT) ? STREAK_SAT : streak_q + 2'd1;
                    end
                    beat_d  = '0;
                    state_d = S_XFER;
                end else if (bus.if_req) begin
                    owner_d  = OWN_IF;
                    addr_d   = bus.if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    streak_d = '0;
                    beat_d   = '0;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                // Shift bytes in MSB-first so beat 0 ends up in bits 31:24.
                if (!we_q) begin
                    rdata_d = {rdata_q[23:0], bus.mem_rdata};
                end
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                if (owner_q == OWN_IF) begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = rdata_q;
                end else begin
                    dm_ack_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = rdata_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory port: driven only during XFER, zero otherwise.
    always_comb begin
        byte_sel      = LAST_BEAT - beat_q;
        wdata_shift   = wdata_q >> {byte_sel, 3'b000};
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (state_q == S_XFER) begin
            bus.mem_addr  = addr_q + ADDR_W'(beat_q);
            // A reset arriving on this edge must not commit the current byte.
            bus.mem_we    = we_q & reset;
            bus.mem_wdata = we_q ? wdata_shift[7:0] : 8'h00;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            streak_q   <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            streak_q   <= streak_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.if_ack   = if_ack_q;
    assign bus.dm_ack   = dm_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a word-level reference model
// predicts grant order, read data and memory contents; a monitor checks
// every ack against the queued expectations.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(8)) bus ();

    mem_port_arbiter #(.ADDR_W(8), .WORD_BYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Byte memory behind the arbiter, plus a preload path for the bench.
    logic [7:0] mem [256];
    logic       pl_we   = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // Reference model state.
    logic [7:0]  ref_mem [256];
    int          ref_streak = 0;
    logic [31:0] ref_if_rd  = 32'h0;
    logic [31:0] ref_dm_rd  = 32'h0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];
    bit          ack_log[$];
    bit          pred_log[$];
    logic [16:0] trace[$];
    logic [16:0] exp_trace[$];
    bit          trace_en = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Arbitration rule; returns 1 when the data port wins.
    function automatic bit ref_pick_dm(input bit ifr, input bit dmr);
        if (dmr && !(ifr && ref_streak == 2)) begin
            if (ifr && ref_streak < 2) ref_streak++;
            return 1'b1;
        end
        ref_streak = 0;
        return 1'b0;
    endfunction

    // Word transfer against the model memory; returns the owner's rdata after ack.
    function automatic logic [31:0] ref_serve(input bit is_dm, input logic [7:0] a,
                                              input bit we, input logic [31:0] wd);
        logic [31:0] w;
        int ad;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ad = (int'(a) + i) % 256;
            if (we) ref_mem[ad] = 8'((wd >> (8 * (3 - i))) & 32'hff);
            else    w = w * 256 + 32'(ref_mem[ad]);
        end
        if (!is_dm) begin
            ref_if_rd = w;
            return w;
        end
        if (!we) ref_dm_rd = w;
        return ref_dm_rd;
    endfunction

    function automatic void expect_txn(input bit is_dm, input logic [7:0] a,
                                       input bit we, input logic [31:0] wd);
        logic [31:0] r;
        r = ref_serve(is_dm, a, we, wd);
        if (is_dm) exp_dm_q.push_back(r);
        else       exp_if_q.push_back(r);
        pred_log.push_back(is_dm);
    endfunction

    function automatic void fill_exp_trace(input logic [7:0] a, input bit we, input logic [31:0] wd);
        logic [7:0] ad;
        logic [7:0] b;
        exp_trace.delete();
        for (int i = 0; i < 4; i++) begin
            ad = 8'((int'(a) + i) % 256);
            b  = we ? 8'((wd >> (8 * (3 - i))) & 32'hff) : 8'h00;
            exp_trace.push_back({ad, we, b});
        end
        exp_trace.push_back(17'h0);
    endfunction

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v;
        v = 32'h0;
        foreach (q[i]) v = v * 2 + 32'(q[i]);
        return v;
    endfunction

    // Monitor: busy-cycle memory trace and ack scoreboard.
    always @(negedge clk) begin
        if (trace_en && bus.busy) trace.push_back({bus.mem_addr, bus.mem_we, bus.mem_wdata});
        if (bus.if_ack) begin
            ack_log.push_back(1'b0);
            if (exp_if_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL if_ack_unexpected: got if_ack=1, expected no ack");
            end else chk("if_rdata", bus.if_rdata, exp_if_q.pop_front());
        end
        if (bus.dm_ack) begin
            ack_log.push_back(1'b1);
            if (exp_dm_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL dm_ack_unexpected: got dm_ack=1, expected no ack");
            end else chk("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {bus.busy, bus.if_ack, bus.dm_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'h0);
        chk("reset_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
        reset = 1'b1;
        ref_streak = 0; ref_if_rd = 32'h0; ref_dm_rd = 32'h0;
    endtask

    task automatic if_txn(input logic [7:0] a, output int lat);
        int n = 0;
        bus.if_req = 1'b1; bus.if_addr = a;
        do begin @(negedge clk); n++; end while (!bus.if_ack && n < 200);
        if (!bus.if_ack) begin
            tests++; fails++;
            $display("FAIL if_timeout: got no if_ack after %0d cycles, expected ack", n);
        end
        lat = n;
        bus.if_req = 1'b0;
    endtask

    task automatic dm_txn(input logic [7:0] a, input bit we, input logic [31:0] wd, output int lat);
        int n = 0;
        bus.dm_req = 1'b1; bus.dm_addr = a; bus.dm_we = we; bus.dm_wdata = wd;
        do begin @(negedge clk); n++; end while (!bus.dm_ack && n < 200);
        if (!bus.dm_ack) begin
            tests++; fails++;
            $display("FAIL dm_timeout: got no dm_ack after %0d cycles, expected ack", n);
        end
        lat = n;
        bus.dm_req = 1'b0;
    endtask

    task automatic compare_trace(input string name);
        logic [16:0] m;
        chk({name, "_len"}, trace.size(), exp_trace.size());
        for (int i = 0; i < trace.size() && i < exp_trace.size(); i++) begin
            // Read beats leave mem_wdata unconstrained; the ACK entry is fully checked.
            m = (exp_trace[i][8] || i == exp_trace.size() - 1) ? 17'h1ffff : 17'h1ff00;
            chk(name, trace[i] & m, exp_trace[i] & m);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_if_q.size() != 0 || exp_dm_q.size() != 0) && n < 100) begin
            @(negedge clk); n++;
        end
        chk({name, "_pending"}, exp_if_q.size() + exp_dm_q.size(), 0);
        exp_if_q.delete(); exp_dm_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, lat_if, lat_dm, n, acks, mism, kind;
        bit d, first_dm;
        logic [7:0] a_if, a_dm;
        logic [31:0] wd;
        bit we;

        bus.if_req = 1'b0; bus.if_addr = 8'h00;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 8'h00; bus.dm_wdata = 32'h0;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        do_reset();

        // Fetch at address 0.
        poke(8'd0, 8'h20); poke(8'd1, 8'h0a); poke(8'd2, 8'h00); poke(8'd3, 8'h0a);
        void'(ref_pick_dm(1'b1, 1'b0));
        expect_txn(1'b0, 8'd0, 1'b0, 32'h0);
        if_txn(8'd0, lat);
        chk("fetch_latency", lat, 6);
        chk("fetch_word", bus.if_rdata, 32'h200a000a);
        drain("fetch");

        // Data write at 10, then read back.
        trace.delete(); trace_en = 1'b1;
        void'(ref_pick_dm(1'b0, 1'b1));
        expect_txn(1'b1, 8'd10, 1'b1, 32'h00000015);
        dm_txn(8'd10, 1'b1, 32'h00000015, lat);
        trace_en = 1'b0;
        fill_exp_trace(8'd10, 1'b1, 32'h00000015);
        compare_trace("write10_trace");
        chk("write10_mem", {mem[10], mem[11], mem[12], mem[13]}, 32'h00000015);
        void'(ref_pick_dm(1'b0, 1'b1));
        expect_txn(1'b1, 8'd10, 1'b0, 32'h0);
        dm_txn(8'd10, 1'b0, 32'h0, lat);
        chk("read10_word", bus.dm_rdata, 32'h00000015);
        drain("write_read");

        // Wrap-around read at 254.
        poke(8'd254, 8'haa); poke(8'd255, 8'hbb); poke(8'd0, 8'h20); poke(8'd1, 8'h0a);
        trace.delete(); trace_en = 1'b1;
        void'(ref_pick_dm(1'b1, 1'b0));
        expect_txn(1'b0, 8'd254, 1'b0, 32'h0);
        if_txn(8'd254, lat);
        trace_en = 1'b0;
        fill_exp_trace(8'd254, 1'b0, 32'h0);
        compare_trace("wrap_trace");
        chk("wrap_word", bus.if_rdata, 32'haabb200a);
        drain("wrap");

        // Both requests held high for six grants.
        do_reset();
        ack_log.delete(); pred_log.delete();
        for (int g = 0; g < 6; g++) begin
            d = ref_pick_dm(1'b1, 1'b1);
            if (d) expect_txn(1'b1, 8'h40, 1'b0, 32'h0);
            else   expect_txn(1'b0, 8'd4, 1'b0, 32'h0);
        end
        bus.if_addr = 8'd4; bus.dm_addr = 8'h40; bus.dm_we = 1'b0;
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        acks = 0; n = 0;
        while (acks < 6 && n < 200) begin
            @(negedge clk); n++;
            if (bus.if_ack || bus.dm_ack) acks++;
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        @(negedge clk);
        chk("held_grant_order", {32'(ack_log.size()), pack(ack_log)}, {32'(pred_log.size()), pack(pred_log)});
        drain("held");

        // Reset during beat 2 of a write at 20.
        poke(8'd22, 8'h5a); poke(8'd23, 8'ha5);
        bus.dm_addr = 8'd20; bus.dm_we = 1'b1; bus.dm_wdata = 32'h11223344; bus.dm_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_beat2_addr", bus.mem_addr, 8'd22);
        reset = 1'b0; bus.dm_req = 1'b0;
        @(negedge clk);
        chk("midreset_busy", bus.busy, 1'b0);
        reset = 1'b1;
        ref_mem[20] = 8'h11; ref_mem[21] = 8'h22;
        ref_streak = 0; ref_if_rd = 32'h0; ref_dm_rd = 32'h0;
        chk("midreset_mem", {mem[20], mem[21], mem[22], mem[23]}, 32'h11225aa5);
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.if_ack || bus.dm_ack) acks++;
        end
        chk("midreset_no_ack", acks, 0);

        // Data request dropped after one transfer cycle.
        wd = $urandom;
        void'(ref_pick_dm(1'b0, 1'b1));
        expect_txn(1'b1, 8'h80, 1'b1, wd);
        bus.dm_addr = 8'h80; bus.dm_we = 1'b1; bus.dm_wdata = wd; bus.dm_req = 1'b1;
        @(negedge clk);
        bus.dm_req = 1'b0;
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.dm_ack) acks++;
        end
        chk("drop_ack_count", acks, 1);
        chk("drop_idle", bus.busy, 1'b0);
        drain("drop");

        // Randomised rounds: fetch only, data only, or both together.
        for (int r = 0; r < 60; r++) begin
            kind = $urandom_range(0, 2);
            a_if = 8'($urandom); a_dm = 8'($urandom);
            we = 1'($urandom); wd = $urandom;
            ack_log.delete(); pred_log.delete();
            if (kind == 0) begin
                void'(ref_pick_dm(1'b1, 1'b0));
                expect_txn(1'b0, a_if, 1'b0, 32'h0);
                if_txn(a_if, lat_if);
                chk("rnd_if_latency", lat_if, 6);
            end else if (kind == 1) begin
                void'(ref_pick_dm(1'b0, 1'b1));
                expect_txn(1'b1, a_dm, we, wd);
                dm_txn(a_dm, we, wd, lat_dm);
                chk("rnd_dm_latency", lat_dm, 6);
            end else begin
                first_dm = ref_pick_dm(1'b1, 1'b1);
                if (first_dm) begin
                    expect_txn(1'b1, a_dm, we, wd);
                    void'(ref_pick_dm(1'b1, 1'b0));
                    expect_txn(1'b0, a_if, 1'b0, 32'h0);
                end else begin
                    expect_txn(1'b0, a_if, 1'b0, 32'h0);
                    void'(ref_pick_dm(1'b0, 1'b1));
                    expect_txn(1'b1, a_dm, we, wd);
                end
                fork
                    if_txn(a_if, lat_if);
                    dm_txn(a_dm, we, wd, lat_dm);
                join
                chk("rnd_pair_latency", {32'(lat_if), 32'(lat_dm)},
                    first_dm ? {32'd12, 32'd6} : {32'd6, 32'd12});
            end
            @(negedge clk);
            chk("rnd_grant_order", {32'(ack_log.size()), pack(ack_log)}, {32'(pred_log.size()), pack(pred_log)});
            drain("rnd");
        end

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the byte address width (256-byte memory).
REQ-002 The block SHALL have parameter WORD_BYTES, default 4, giving the number of bytes per word.
REQ-003 Port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset; reset==0 sampled at a clk edge resets the block.
REQ-005 Port if_req, input, 1: fetch read request, held until if_ack.
REQ-006 Port if_addr, input, ADDR_W: fetch byte address.
REQ-007 Port if_ack, output, 1: one-cycle fetch completion pulse.
REQ-008 Port if_rdata, output, 32: fetched word.
REQ-009 Port dm_req, input, 1: data request, held until dm_ack.
REQ-010 Port dm_we, input, 1: 1 means write, 0 means read.
REQ-011 Port dm_addr, input, ADDR_W: data byte address.
REQ-012 Port dm_wdata, input, 32: data write word.
REQ-013 Port dm_ack, output, 1: one-cycle data completion pulse.
REQ-014 Port dm_rdata, output, 32: data read word.
REQ-015 Port mem_addr, output, ADDR_W: byte address to the shared memory.
REQ-016 Port mem_we, output, 1: byte write strobe, written at the next clk edge.
REQ-017 Port mem_wdata, output, 8: byte to write.
REQ-018 Port mem_rdata, input, 8: combinational (same-cycle) read byte.
REQ-019 Port busy, output, 1: high in every state other than IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE -> XFER (4 beats) -> ACK -> IDLE.
REQ-021 In IDLE, a sampled request SHALL latch the owner, address, we and wdata, clear the beat counter and enter XFER.
REQ-022 XFER beat b (0..3) SHALL drive mem_addr = (base + b) mod 2^ADDR_W, with no alignment required and wrap-around allowed.
REQ-023 Byte order SHALL be big-endian: beat 0 carries bits 31:24 and beat 3 carries bits 7:0.
REQ-024 Read beats SHALL capture mem_rdata at each edge, and mem_we SHALL be 0 throughout a read.
REQ-025 Write beats SHALL drive mem_we=1 and mem_wdata equal to the latched word byte for that beat.
REQ-026 After beat 3, the FSM SHALL enter ACK; there it asserts the owner's ack for exactly one cycle and updates that owner's rdata, which holds until that owner's next read completes.
REQ-027 A data write ack SHALL leave dm_rdata unchanged.
REQ-028 ACK SHALL always return to IDLE without sampling requests; latency from the request-sampling edge to ack high is 5 cycles, and throughput is one word per 6 cycles.
REQ-029 Outside XFER, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-030 When both requests are present in IDLE, dm SHALL win unless streak==2, in which case if wins.
REQ-031 streak SHALL increment (saturating at 2) on each dm grant made while if_req is high, and SHALL clear on each if grant.
REQ-032 A request dropped mid-transfer SHALL NOT abort the transfer; the ack still pulses.
REQ-033 Requests arriving during XFER or ACK SHALL wait; they are never lost.

Reset
REQ-034 When reset==0, the block SHALL enter IDLE, clear the beat counter and streak, and set if_ack, dm_ack, mem_we and busy to 0 and if_rdata, dm_rdata, mem_addr and mem_wdata to 0.
REQ-035 A reset mid-XFER SHALL issue no ack; bytes written before the reset edge remain written, and later bytes are not written.

Structure
REQ-036 Package mips_mem_pkg SHALL hold the state enum (IDLE, XFER, ACK), WORD_BYTES, STREAK_MAX=2 and the owner enum (OWN_IF, OWN_DM).
REQ-037 The block SHALL be a single module with no sub-module; the memory array stays outside it.

Verification
REQ-038 Bench SHALL cover fetch at addr 0 with mem[0..3]=20,0a,00,0a -> if_ack high 5 cycles after sampling, if_rdata=0x200a000a, dm_ack stays 0.
REQ-039 Bench SHALL cover dm write at addr 10 with wdata 0x00000015 -> mem_we on 4 beats, bytes 00,00,00,15 at addrs 10..13; a following dm read at addr 10 gives dm_rdata=0x00000015.
REQ-040 Bench SHALL cover if_req (addr 4) and dm_req held continuously high -> grant order dm, dm, if, then repeating.
REQ-041 Bench SHALL cover a read at addr 254 with mem[254]=aa, [255]=bb, [0]=20, [1]=0a -> mem_addr sequence 254, 255, 0, 1 and rdata=0xaabb200a.
REQ-042 Bench SHALL cover reset=0 during beat 2 of a write of 0x11223344 at addr 20 -> next cycle IDLE, busy=0, no ack, mem[20..21]=11,22, mem[22..23] unchanged.
REQ-043 Bench SHALL cover dm_req dropped after one XFER cycle -> dm_ack still pulses once, then the FSM returns to IDLE.
